// File: rtl/stopwatch_apb_bridge.sv
// APB slave front end for the stopwatch pin interface: one rwenable strobe per transfer, count gating, reset sync.
// Optional decode with SLVERR is enabled by defining STOPWATCH_BRIDGE_ERR_EN.
module stopwatch_apb_bridge #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic              count_en,
  output logic              sw_reset,
  output logic              sw_count,
  output logic              sw_rwenable,
  output logic              sw_rw,
  output logic [31:0]       sw_addr,
  output logic [31:0]       sw_data_i,
  input  logic [31:0]       sw_data_o,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] RESP    = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        rst_meta_q, sw_reset_q;
  logic        count_en_q;
  logic        sw_rwenable_q, sw_rw_q, pready_q, pslverr_q, busy_q;
  logic [31:0] sw_addr_q, sw_data_q, prdata_q;
  logic [31:0] idx;
  logic        illegal;
  logic        unused_ok;

  // The transfer is accepted in either APB phase, so penable carries no information here.
  assign unused_ok = &{1'b0, penable, paddr[1:0]};
  assign idx       = 32'(paddr[ADDR_W-1:2]);

`ifdef STOPWATCH_BRIDGE_ERR_EN
  // Index 14+ also covers any address bits above the 6-bit index space.
  assign illegal = (idx >= 32'd14) || (pwrite && (idx == 32'd1));
`else
  assign illegal = 1'b0;
`endif

  // Stopwatch reset asserts with reset_n and releases two clock edges later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      sw_reset_q <= 1'b1;
    end else begin
      rst_meta_q <= 1'b1;
      sw_reset_q <= ~rst_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (psel && !sw_reset_q) state_d = illegal ? RESP : ISSUE;
      ISSUE:   state_d = sw_rw_q ? CAPTURE : RESP;
      CAPTURE: state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      count_en_q    <= 1'b0;
      sw_rwenable_q <= 1'b0;
      sw_rw_q       <= 1'b0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      busy_q        <= 1'b0;
      sw_addr_q     <= '0;
      sw_data_q     <= '0;
      prdata_q      <= '0;
    end else begin
      state_q       <= state_d;
      count_en_q    <= count_en;
      sw_rwenable_q <= (state_d == ISSUE);
      pready_q      <= (state_d == RESP);
      pslverr_q     <= (state_q == IDLE) && (state_d == RESP);
      busy_q        <= (state_d != IDLE);
      if ((state_q == IDLE) && (state_d == ISSUE)) begin
        sw_rw_q   <= ~pwrite;
        sw_addr_q <= idx;
        sw_data_q <= pwdata;
      end
      if (state_q == CAPTURE) prdata_q <= sw_data_o;
    end
  end

  // Counting is held off for the whole access so data_o stays stable until capture.
  assign sw_count    = count_en_q & (state_q == IDLE) & ~sw_reset_q;
  assign sw_reset    = sw_reset_q;
  assign sw_rwenable = sw_rwenable_q;
  assign sw_rw       = sw_rw_q;
  assign sw_addr     = sw_addr_q;
  assign sw_data_i   = sw_data_q;
  assign prdata      = prdata_q;
  assign pready      = pready_q;
  assign pslverr     = pslverr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_stopwatch_apb_bridge.sv
// Directed bench for stopwatch_apb_bridge with a small behavioural stopwatch register model.
module tb_stopwatch_apb_bridge;

  logic        clk;
  logic        reset_n;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr, count_en;
  logic        sw_reset, sw_count, sw_rwenable, sw_rw, busy;
  logic [31:0] sw_addr, sw_data_i, sw_data_o;

  int checks = 0;
  int failures = 0;

  stopwatch_apb_bridge #(.ADDR_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .count_en(count_en), .sw_reset(sw_reset), .sw_count(sw_count), .sw_rwenable(sw_rwenable),
    .sw_rw(sw_rw), .sw_addr(sw_addr), .sw_data_i(sw_data_i), .sw_data_o(sw_data_o), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stopwatch model: index 1 is the running count, index 4 resets to 10.
  logic [31:0] mem [64];
  logic [31:0] cnt;
  always @(posedge clk) begin
    if (sw_reset) begin
      for (int i = 0; i < 64; i++) mem[i] <= (i == 4) ? 32'd10 : 32'd0;
      cnt       <= '0;
      sw_data_o <= '0;
    end else begin
      if (sw_count) begin
        cnt       <= cnt + 32'd1;
        sw_data_o <= cnt + 32'd1;
      end
      if (sw_rwenable) begin
        if (sw_rw) sw_data_o <= (sw_addr[5:0] == 6'd1) ? cnt : mem[sw_addr[5:0]];
        else if (sw_addr[5:0] == 6'd1) cnt <= sw_data_i;
        else mem[sw_addr[5:0]] <= sw_data_i;
      end
    end
  end

  int          n_strobe = 0;
  int          n_resp = 0;
  int          gate_viol = 0;
  logic [31:0] last_addr = '0, last_dat = '0, cnt_at_strobe = '0;
  logic        last_rw = 1'b0;
  always @(posedge clk) begin
    if (sw_rwenable) begin
      n_strobe  <= n_strobe + 1;
      last_addr <= sw_addr;
      last_dat  <= sw_data_i;
      last_rw   <= sw_rw;
      if (sw_rw && sw_addr == 32'd1) cnt_at_strobe <= cnt;
    end
    if (pready) n_resp <= n_resp + 1;
    if (busy && sw_count) gate_viol <= gate_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge while the FSM is idle; returns #1 after the edge ending RESP.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 1;
    while (!pready && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = prdata;
    er = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  logic [31:0] rd, pr_prev;
  logic        er;
  int          lat, s0, r0, gv0;
  logic [7:0]  a;

  initial begin
    reset_n = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; count_en = 1'b0;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sw_reset",  32'(sw_reset), 32'd1);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_pready",    32'(pready), 32'd0);
    chk("rst_pslverr",   32'(pslverr), 32'd0);
    chk("rst_prdata",    prdata, 32'd0);
    chk("rst_rwenable",  32'(sw_rwenable), 32'd0);
    chk("rst_rw",        32'(sw_rw), 32'd0);
    chk("rst_count",     32'(sw_count), 32'd0);
    chk("rst_addr",      sw_addr, 32'd0);
    chk("rst_data_i",    sw_data_i, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rel_edge1", 32'(sw_reset), 32'd1);
    @(posedge clk); #1;
    chk("rst_rel_edge2", 32'(sw_reset), 32'd0);

    // Write 0x20 to index 3, then read it back.
    s0 = n_strobe;
    apb(1'b1, 8'h0C, 32'h20, rd, er, lat);
    chk("wr_lat",    32'(lat), 32'd2);
    chk("wr_err",    32'(er), 32'd0);
    chk("wr_strobe", 32'(n_strobe - s0), 32'd1);
    chk("wr_addr",   last_addr, 32'd3);
    chk("wr_rw",     32'(last_rw), 32'd0);
    chk("wr_data",   last_dat, 32'h20);
    apb(1'b0, 8'h0C, 32'h0, rd, er, lat);
    chk("rd_lat",    32'(lat), 32'd3);
    chk("rd_data",   rd, 32'h20);
    chk("rd_rw",     32'(last_rw), 32'd1);
    chk("rd_addr",   last_addr, 32'd3);

    // Count gating around a read of the count register.
    count_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("cnt_idle", 32'(sw_count), 32'd1);
    gv0 = gate_viol;
    apb(1'b0, 8'h04, 32'h0, rd, er, lat);
    chk("cnt_rd_data",  rd, cnt_at_strobe);
    chk("cnt_rd_nz",    32'(rd != 0), 32'd1);
    chk("cnt_gated",    32'(gate_viol - gv0), 32'd0);
    chk("cnt_reassert", 32'(sw_count), 32'd1);
    count_en = 1'b0;
    @(posedge clk); #1;
    pr_prev = prdata;

    // Decode of illegal accesses.
    s0 = n_strobe;
    apb(1'b1, 8'h04, 32'h55, rd, er, lat);
`ifdef STOPWATCH_BRIDGE_ERR_EN
    chk("err_wr_slverr", 32'(er), 32'd1);
    chk("err_wr_lat",    32'(lat), 32'd1);
    chk("err_wr_strobe", 32'(n_strobe - s0), 32'd0);
`else
    chk("err_wr_slverr", 32'(er), 32'd0);
    chk("err_wr_lat",    32'(lat), 32'd2);
    chk("err_wr_strobe", 32'(n_strobe - s0), 32'd1);
`endif
    s0 = n_strobe;
    apb(1'b0, 8'h38, 32'h0, rd, er, lat);
`ifdef STOPWATCH_BRIDGE_ERR_EN
    chk("err_rd_slverr", 32'(er), 32'd1);
    chk("err_rd_lat",    32'(lat), 32'd1);
    chk("err_rd_strobe", 32'(n_strobe - s0), 32'd0);
    chk("err_rd_prdata", rd, pr_prev);
`else
    chk("err_rd_slverr", 32'(er), 32'd0);
    chk("err_rd_lat",    32'(lat), 32'd3);
    chk("err_rd_strobe", 32'(n_strobe - s0), 32'd1);
    chk("err_rd_prdata", rd, 32'd0);
`endif
    chk("err_idle_slverr", 32'(pslverr), 32'd0);

    // Reset asserted in the CAPTURE cycle of a read.
    s0 = n_strobe;
    r0 = n_resp;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    psel = 1'b0; penable = 1'b0;
    #1;
    chk("mid_idle",     32'(busy), 32'd0);
    chk("mid_sw_reset", 32'(sw_reset), 32'd1);
    chk("mid_pready",   32'(pready), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rel",      32'(sw_reset), 32'd0);
    chk("mid_strobes",  32'(n_strobe - s0), 32'd1);
    chk("mid_no_resp",  32'(n_resp - r0), 32'd0);
    apb(1'b0, 8'h10, 32'h0, rd, er, lat);
    chk("mid_rd_lat",   32'(lat), 32'd3);
    chk("mid_rd_data",  rd, 32'd10);

    // Back-to-back writes to indices 6..13, then readback.
    s0 = n_strobe;
    for (int i = 0; i < 8; i++) begin
      a = 8'((6 + i) * 4);
      apb(1'b1, a, 32'hA0 + 32'(i), rd, er, lat);
      chk("b2b_wr_lat", 32'(lat), 32'd2);
    end
    for (int i = 0; i < 8; i++) begin
      a = 8'((6 + i) * 4);
      apb(1'b0, a, 32'h0, rd, er, lat);
      chk("b2b_rd_data", rd, 32'hA0 + 32'(i));
    end
    chk("b2b_strobes", 32'(n_strobe - s0), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
